// File: rtl/fre_bcd_display_if.sv
// rtl/fre_bcd_display_if.sv - value input and BCD/display outputs of the display stage
interface fre_bcd_display_if;
  logic [9:0]  displayfre;
  logic [15:0] bcd;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  sseg;

  modport master (
    output displayfre,
    input  bcd,
    input  busy,
    input  an,
    input  sseg
  );

  modport slave (
    input  displayfre,
    output bcd,
    output busy,
    output an,
    output sseg
  );
endinterface

// File: rtl/fre_bcd_display.sv
// rtl/fre_bcd_display.sv - double-dabble BCD conversion and multiplexed 7-segment drive
module fre_bcd_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic              clk,
  input  logic              reset,
  fre_bcd_display_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state, w_state_nx;
  logic [9:0]  r_last_val, w_last_val_nx;
  logic        r_first, w_first_nx;
  logic [9:0]  r_bin_sh, w_bin_sh_nx;
  logic [15:0] r_bcd_sh, w_bcd_sh_nx;
  logic [3:0]  r_it, w_it_nx;
  logic [15:0] r_bcd, w_bcd_nx;
  logic        r_busy, w_busy_nx;
  logic [REFRESH_BITS-1:0] r_refresh;

  logic [15:0] w_bcd_adj;
  logic [1:0]  w_sel;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [7:0]  w_seg;

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    w_bcd_adj = r_bcd_sh;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd_sh[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd_sh[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM next-state and datapath; bcd only loads from DONE so it never shows partial data
  always_comb begin
    w_state_nx    = r_state;
    w_last_val_nx = r_last_val;
    w_first_nx    = r_first;
    w_bin_sh_nx   = r_bin_sh;
    w_bcd_sh_nx   = r_bcd_sh;
    w_it_nx       = r_it;
    w_bcd_nx      = r_bcd;
    w_busy_nx     = r_busy;
    case (r_state)
      S_IDLE: begin
        if (r_first || (bus.displayfre != r_last_val)) begin
          w_bin_sh_nx   = bus.displayfre;
          w_last_val_nx = bus.displayfre;
          w_bcd_sh_nx   = 16'd0;
          w_it_nx       = 4'd0;
          w_first_nx    = 1'b0;
          w_busy_nx     = 1'b1;
          w_state_nx    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {w_bcd_sh_nx, w_bin_sh_nx} = {w_bcd_adj[14:0], r_bin_sh, 1'b0};
        w_it_nx = r_it + 4'd1;
        if (r_it == 4'd9)
          w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_bcd_nx   = r_bcd_sh;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Conversion state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_val <= 10'd0;
      r_first    <= 1'b1;
      r_bin_sh   <= 10'd0;
      r_bcd_sh   <= 16'd0;
      r_it       <= 4'd0;
      r_bcd      <= 16'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_last_val <= w_last_val_nx;
      r_first    <= w_first_nx;
      r_bin_sh   <= w_bin_sh_nx;
      r_bcd_sh   <= w_bcd_sh_nx;
      r_it       <= w_it_nx;
      r_bcd      <= w_bcd_nx;
      r_busy     <= w_busy_nx;
    end
  end

  // Free-running refresh counter; its top two bits pick the lit digit
  always_ff @(posedge clk) begin
    if (reset)
      r_refresh <= '0;
    else
      r_refresh <= r_refresh + 1'b1;
  end

  assign w_sel   = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_digit = r_bcd[{w_sel, 2'b00} +: 4];

  // Leading-zero blanking: a digit is dark when it and every digit above it are zero
  always_comb begin
    w_blank = 1'b0;
    case (w_sel)
      2'd1:    w_blank = (r_bcd[15:4] == 12'd0);
      2'd2:    w_blank = (r_bcd[15:8] == 8'd0);
      2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end

  // Active-low segment decode, dp off; non-decimal nibbles go dark
  always_comb begin
    w_seg = 8'hFF;
    case (w_digit)
      4'd0: w_seg = 8'hC0;
      4'd1: w_seg = 8'hF9;
      4'd2: w_seg = 8'hA4;
      4'd3: w_seg = 8'hB0;
      4'd4: w_seg = 8'h99;
      4'd5: w_seg = 8'h92;
      4'd6: w_seg = 8'h82;
      4'd7: w_seg = 8'hF8;
      4'd8: w_seg = 8'h80;
      4'd9: w_seg = 8'h90;
      default: w_seg = 8'hFF;
    endcase
  end

  assign bus.bcd  = r_bcd;
  assign bus.busy = r_busy;
  assign bus.an   = w_blank ? 4'b1111 : ~(4'b0001 << w_sel);
  assign bus.sseg = w_blank ? 8'hFF : w_seg;

endmodule

// File: tb/tb_fre_bcd_display.sv
// tb/tb_fre_bcd_display.sv - scoreboard bench for fre_bcd_display
module tb_fre_bcd_display;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [15:0] exp_q[$];

  fre_bcd_display_if bus();

  fre_bcd_display #(.REFRESH_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] disp_exp(input logic [15:0] b, input logic [1:0] s);
    logic [15:0] up;
    logic [7:0]  seg;
    logic [3:0]  a;
    up = b >> (4 * s);
    case (up[3:0])
      4'd0: seg = 8'hC0;  4'd1: seg = 8'hF9;  4'd2: seg = 8'hA4;  4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;  4'd5: seg = 8'h92;  4'd6: seg = 8'h82;  4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;  4'd9: seg = 8'h90;  default: seg = 8'hFF;
    endcase
    if (s != 2'd0 && up == 16'd0) return {4'hF, 8'hFF};
    a = 4'b1111;
    a[s] = 1'b0;
    return {a, seg};
  endfunction

  task automatic drive(input int v);
    bus.displayfre = 10'(v);
    exp_q.push_back(bcd_of(v));
  endtask

  task automatic watch(input int maxc, output int n_cyc, output int gap);
    logic [15:0] prev;
    int lows;
    bit fell;
    bit done_flag;
    prev = bus.bcd; n_cyc = 0; gap = -1; lows = 0; fell = 0; done_flag = 0;
    for (int i = 1; i <= maxc && !done_flag; i++) begin
      @(negedge clk);
      if (bus.bcd !== prev) begin
        if (exp_q.size() == 0) chk("unexpected_bcd", bus.bcd, prev);
        else                   chk("bcd_result", bus.bcd, exp_q.pop_front());
        prev = bus.bcd; n_cyc = i; fell = 1; lows = 0;
      end
      if (fell && !bus.busy) lows++;
      if (fell && bus.busy && gap < 0) gap = lows;
      if (exp_q.size() == 0 && !bus.busy && n_cyc > 0) done_flag = 1;
    end
    chk("watch_done", 32'(done_flag), 32'd1);
  endtask

  task automatic chk_slot(input string tag, input logic [1:0] k, input logic [3:0] an_e, input logic [7:0] sseg_e);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cyc[3:2] == k) found = 1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    chk({tag, "_an"}, bus.an, an_e);
    chk({tag, "_sseg"}, bus.sseg, sseg_e);
  endtask

  task automatic scan(input string tag, input int n, input logic [15:0] b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {bus.an, bus.sseg}, disp_exp(b, cyc[3:2]));
    end
  endtask

  initial begin
    int n, gap;

    // 1: reset state, then 30
    bus.displayfre = 10'd30;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bus.bcd, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_an", bus.an, 4'b1110);
    chk("rst_sseg", bus.sseg, 8'hC0);
    exp_q.push_back(bcd_of(30));
    reset = 1'b0;
    watch(40, n, gap);
    chk("lat30", n, 12);
    chk("bcd30", bus.bcd, 16'h0030);
    chk_slot("t30_s0", 2'd0, 4'b1110, 8'hC0);
    chk_slot("t30_s1", 2'd1, 4'b1101, 8'hB0);
    chk_slot("t30_s2", 2'd2, 4'b1111, 8'hFF);
    chk_slot("t30_s3", 2'd3, 4'b1111, 8'hFF);
    scan("scan30", 16, 16'h0030);

    // 2: 200, tens zero stays lit
    drive(200);
    watch(40, n, gap);
    chk("lat200", n, 12);
    chk("bcd200", bus.bcd, 16'h0200);
    chk_slot("t200_s0", 2'd0, 4'b1110, 8'hC0);
    chk_slot("t200_s1", 2'd1, 4'b1101, 8'hC0);
    chk_slot("t200_s2", 2'd2, 4'b1011, 8'hA4);
    chk_slot("t200_s3", 2'd3, 4'b1111, 8'hFF);

    // 3: 1023, all four digits lit
    drive(1023);
    watch(40, n, gap);
    chk("lat1023", n, 12);
    chk("bcd1023", bus.bcd, 16'h1023);
    chk_slot("t1023_s0", 2'd0, 4'b1110, 8'hB0);
    chk_slot("t1023_s1", 2'd1, 4'b1101, 8'hA4);
    chk_slot("t1023_s2", 2'd2, 4'b1011, 8'hC0);
    chk_slot("t1023_s3", 2'd3, 4'b0111, 8'hF9);

    // 4: 75, then 125 with 150 arriving on the 5th SHIFT cycle
    drive(75);
    watch(40, n, gap);
    chk("bcd75", bus.bcd, 16'h0075);
    drive(125);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_busy_hold", bus.busy, 1'b1);
      chk("t4_bcd_hold", bus.bcd, 16'h0075);
    end
    drive(150);
    watch(60, n, gap);
    chk("t4_gap", gap, 1);
    chk("t4_lat", n, 19);
    chk("bcd150", bus.bcd, 16'h0150);

    // 5: reset on the 6th SHIFT cycle of 175
    bus.displayfre = 10'd175;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_bcd_hold", bus.bcd, 16'h0150);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_bcd", bus.bcd, 16'h0000);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_an", bus.an, 4'b1110);
    exp_q.push_back(bcd_of(175));
    reset = 1'b0;
    watch(40, n, gap);
    chk("lat175", n, 12);
    chk("bcd175", bus.bcd, 16'h0175);

    // 6: hold 100 steady for 200 cycles
    drive(100);
    watch(40, n, gap);
    chk("bcd100", bus.bcd, 16'h0100);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("t6_busy", bus.busy, 1'b0);
      chk("t6_bcd", bus.bcd, 16'h0100);
      chk("t6_disp", {bus.an, bus.sseg}, disp_exp(16'h0100, cyc[3:2]));
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fre_bcd_display.md
# fre_bcd_display

Display stage downstream of the frequency decoder: it takes the 10-bit binary frequency value `displayfre` (30–200 in normal use, 0–1023 legal) and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits onto a 4-digit common-anode seven-segment display with leading-zero blanking. Conversion runs only when the input changes, so the display never shows a partially converted value.

## Interface
- `REFRESH_BITS`, default 18: width of the free-running refresh counter; its top 2 bits select the active digit. At 100 MHz each digit is lit for 2^16 cycles.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `displayfre`  in  10  binary value to display; may change at any cycle.
- `bcd`  out  16  last completed conversion: {thousands, hundreds, tens, units}, 4 bits each.
- `busy`  out  1  high while a conversion is in progress (SHIFT or DONE state).
- `an`  out  4  digit anodes, active-low; `an[0]` is the units digit (rightmost).
- `sseg`  out  8  segments, active-low: `sseg[0]`=a … `sseg[6]`=g, `sseg[7]`=dp. The decimal point is always off (1).

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE.
- Internal registers:
  - `last_val` (10 bits): value last captured.
  - `first` flag: set by reset.
  - `bin_sh` (10 bits), `bcd_sh` (16 bits), `it` (4-bit iteration count).
- IDLE:
  - If `first`=1 or `displayfre` != `last_val`: capture `bin_sh`<=`displayfre` and `last_val`<=`displayfre`, clear `bcd_sh` and `it`, clear `first`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Each `bcd_sh` nibble ≥5 gets +3 (all four nibbles in parallel).
  - Then {`bcd_sh`,`bin_sh`} shifts left by 1.
  - `it`++. When `it`=9 (the 10th iteration), go to DONE.
- DONE: `bcd`<=`bcd_sh`, go to IDLE.
- Changes to `displayfre` during SHIFT or DONE are ignored. On return to IDLE the input is compared against `last_val`, and a new conversion starts if they differ.
- `bcd` holds its value between conversions. It never shows intermediate data.
- Refresh counter:
  - `REFRESH_BITS` wide, increments every cycle, wraps to 0.
  - `sel` = top 2 bits; `sel`=k drives `an[k]`=0 with the other anodes 1, and the segments decoded from `bcd` digit k.
- Blanking: digit k>0 is blanked (`an`=1111, `sseg`=8'hFF) when digits k..3 are all zero. The units digit is never blanked.
- Nibble values 10–15 cannot occur; the decoder drives 8'hFF for them.
- Segment codes with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- `an` and `sseg` are combinational decodes of registered `sel` and `bcd`. There is no added pipeline stage.

## Timing
- Reset values:
  - State=IDLE, `first`=1, `last_val`=0, `bcd`=0, `busy`=0, refresh counter=0.
  - Hence `an`=4'b1110 and `sseg`=8'hC0 while reset is held.
- Latency: the capture edge (IDLE) is edge 0; `bcd` is updated on edge 11 and is visible after it. That is 12 cycles from the first IDLE cycle that sees a change.
- `busy` is registered: high from edge 0 through edge 11, low after edge 11.
- After reset is released, a conversion starts on the first edge, even when `displayfre`=0.
- Reset asserted mid-conversion aborts the conversion immediately. `bcd` returns to 0 and the FSM restarts with `first`=1.
- If the input changes in the same cycle as DONE, the change is detected in the next IDLE cycle. That gives a back-to-back conversion with one IDLE cycle between.
- Each digit is lit for 2^(REFRESH_BITS-2) cycles; the full scan takes 2^REFRESH_BITS cycles.

## Test plan
Benches run with `REFRESH_BITS`=4.

1. Reset, then `displayfre`=30:
   - 12 cycles after release, `bcd`=16'h0030 and `busy` falls.
   - Scan shows an=1110/sseg=C0, an=1101/sseg=B0, then two slots with an=1111/sseg=FF.
2. `displayfre`=200:
   - `bcd`=16'h0200.
   - Tens digit shows C0 (not blanked); thousands slot blanked; hundreds shows A4.
3. `displayfre`=1023:
   - `bcd`=16'h1023.
   - All four digits lit: F9, C0, A4, B0 for thousands down to units.
4. From 75 converted, set 125, then set 150 on the 5th SHIFT cycle:
   - `bcd` goes 0075→0125 (no intermediate value), then 0150.
   - `busy` drops for exactly 1 cycle between the two conversions.
5. Assert `reset` on the 6th SHIFT cycle of a 175 conversion:
   - `bcd`=0 and `busy`=0 during reset.
   - After release, `bcd`=16'h0175 12 cycles later.
6. Hold `displayfre`=100 steady for 200 cycles after its conversion:
   - `busy` stays 0 and `bcd` stays 16'h0100.
   - Refresh counter wraps cleanly, repeating the scan every 16 cycles.
